// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multi-cycle RV32I-style control FSM. Sequences FETCH,
//                DECODE, EXEC, MEM and WB, produces datapath strobes and
//                traps on illegal opcodes or memory wait timeouts.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_control #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       stall,
  output logic       imem_req,
  output logic       ir_we,
  output logic       imm_valid,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       rf_we,
  output logic       pc_we,
  output logic       instr_done,
  output logic       illegal,
  output logic       timeout,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  // CL_NONE doubles as the "illegal opcode" decode result.
  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_LUI    = 4'd1,
    CL_AUIPC  = 4'd2,
    CL_JAL    = 4'd3,
    CL_JALR   = 4'd4,
    CL_BRANCH = 4'd5,
    CL_LOAD   = 4'd6,
    CL_STORE  = 4'd7,
    CL_OPIMM  = 4'd8,
    CL_OP     = 4'd9
  } class_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_IMM    = 2'b01;
  localparam logic [1:0] PC_RS1IMM = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  // Compared against the incremented count, so one bit wider than the counter.
  localparam logic [8:0] MAX_WAIT_C = 9'(MAX_WAIT);

  state_e     state_q, state_d;
  class_e     class_q, class_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;

  class_e     dec_class;
  logic [8:0] wait_inc;
  logic       wait_hit;

  // Opcode to instruction-class decode.
  always_comb begin
    dec_class = CL_NONE;
    case (opcode)
      OPC_LUI:    dec_class = CL_LUI;
      OPC_AUIPC:  dec_class = CL_AUIPC;
      OPC_JAL:    dec_class = CL_JAL;
      OPC_JALR:   dec_class = CL_JALR;
      OPC_BRANCH: dec_class = CL_BRANCH;
      OPC_LOAD:   dec_class = CL_LOAD;
      OPC_STORE:  dec_class = CL_STORE;
      OPC_OPIMM:  dec_class = CL_OPIMM;
      OPC_OP:     dec_class = CL_OP;
      default:    dec_class = CL_NONE;
    endcase
  end

  // A wait cycle without ack that would bring the count to MAX_WAIT traps.
  assign wait_inc = {1'b0, wait_q} + 9'd1;
  assign wait_hit = (wait_inc == MAX_WAIT_C);

  // Next-state and output decode; reset forces every output low except state.
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    wait_d     = 8'd0;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    imm_valid  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    rf_we      = 1'b0;
    pc_we      = 1'b0;
    instr_done = 1'b0;
    pc_src     = PC_PLUS4;
    wb_sel     = WB_ALU;

    case (state_q)
      ST_FETCH: begin
        // Stall is deliberately ignored here: the memory handshake wins.
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_hit) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      ST_DECODE: begin
        if (!stall) begin
          imm_valid = 1'b1;
          class_d   = dec_class;
          if (dec_class == CL_NONE) begin
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        if (!stall) begin
          case (class_q)
            CL_LOAD, CL_STORE: state_d = ST_MEM;
            CL_BRANCH: begin
              pc_we      = 1'b1;
              pc_src     = branch_taken ? PC_IMM : PC_PLUS4;
              instr_done = 1'b1;
              state_d    = ST_FETCH;
            end
            default: state_d = ST_WB;
          endcase
        end
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_q == CL_STORE);
        if (dmem_ack) begin
          if (class_q == CL_STORE) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_hit) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      ST_WB: begin
        case (class_q)
          CL_LUI:          wb_sel = WB_IMM;
          CL_JAL, CL_JALR: wb_sel = WB_PC4;
          CL_LOAD:         wb_sel = WB_LOAD;
          default:         wb_sel = WB_ALU;
        endcase
        case (class_q)
          CL_JAL:  pc_src = PC_IMM;
          CL_JALR: pc_src = PC_RS1IMM;
          default: pc_src = PC_PLUS4;
        endcase
        if (!stall) begin
          rf_we      = 1'b1;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
      end

      ST_TRAP: begin
        // Absorbing: only rst leaves this state.
        state_d = ST_TRAP;
      end

      default: state_d = ST_FETCH;
    endcase

    illegal = illegal_q;
    timeout = timeout_q;
    state   = state_q;

    if (rst) begin
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      imm_valid  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      pc_we      = 1'b0;
      instr_done = 1'b0;
      pc_src     = PC_PLUS4;
      wb_sel     = WB_ALU;
      illegal    = 1'b0;
      timeout    = 1'b0;
      state      = ST_FETCH;
    end
  end

  // State, class, wait counter and trap-cause registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      class_q   <= CL_NONE;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control
//  Description : Directed self-checking bench for mc_control (MAX_WAIT=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_control;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       branch_taken;
  logic       imem_ack;
  logic       dmem_ack;
  logic       stall;
  logic       imem_req, ir_we, imm_valid, dmem_req, dmem_we, rf_we, pc_we;
  logic       instr_done, illegal, timeout;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  mc_control #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .stall        (stall),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .imm_valid    (imm_valid),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .instr_done   (instr_done),
    .illegal      (illegal),
    .timeout      (timeout),
    .pc_src       (pc_src),
    .wb_sel       (wb_sel),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait retirement table: opcode, latency, wb_sel and pc_src at retire, rf_we at retire.
  logic [6:0] tbl_opc [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  int         tbl_lat [9] = '{4, 4, 4, 4, 3, 5, 4, 4, 4};
  logic [1:0] tbl_ws  [9] = '{2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
  logic [1:0] tbl_ps  [9] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic       tbl_rfw [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns into cycle 1 (first cycle after rst deasserts).
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Runs one instruction with both memories acking immediately.
  task automatic run_zero_wait(input logic [6:0] opc, output int lat, output logic [1:0] ws,
                               output logic [1:0] ps, output logic rfw);
    lat = 0; ws = 2'bxx; ps = 2'bxx; rfw = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      opcode = opc;
      #1;
      if (instr_done === 1'b1) begin
        lat = c; ws = wb_sel; ps = pc_src; rfw = rf_we;
      end
      step();
      if (lat != 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    opcode = 7'b0010011;
    step();
    step();
    checks++;
    if ({state, imem_req, ir_we, imm_valid, dmem_req, dmem_we, rf_we, pc_we, instr_done,
         illegal, timeout, pc_src, wb_sel} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: state=%0d imem_req=%b ir_we=%b pc_we=%b expected all zero",
               state, imem_req, ir_we, pc_we);
    end
    rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || state !== 3'd0) begin
      failures++;
      $display("FAIL reset_release: imem_req=%b state=%0d expected 1/0", imem_req, state);
    end
    step();
  endtask

  task automatic test_alu();
    do_reset();
    opcode = 7'b0010011; imem_ack = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || ir_we !== 1'b1) begin
      failures++;
      $display("FAIL alu_c1: state=%0d ir_we=%b expected 0/1", state, ir_we);
    end
    step(); imem_ack = 1'b0; #1;
    checks++;
    if (state !== 3'd1 || imm_valid !== 1'b1) begin
      failures++;
      $display("FAIL alu_c2: state=%0d imm_valid=%b expected 1/1", state, imm_valid);
    end
    step(); #1;
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL alu_c3: state=%0d expected 2", state);
    end
    step(); #1;
    checks++;
    if ({state, rf_we, pc_we, instr_done, wb_sel, pc_src} !== {3'd4, 3'b111, 2'b00, 2'b00}) begin
      failures++;
      $display("FAIL alu_c4: state=%0d rf_we=%b pc_we=%b done=%b wb_sel=%b expected 4/1/1/1/00",
               state, rf_we, pc_we, instr_done, wb_sel);
    end
    step(); #1;
    checks++;
    if (state !== 3'd0 || instr_done !== 1'b0) begin
      failures++;
      $display("FAIL alu_c5: state=%0d done=%b expected 0/0", state, instr_done);
    end
    step();
  endtask

  task automatic test_load();
    int req_cnt = 0;
    int done_c  = 0;
    logic we_seen = 1'b0;
    logic [1:0] ws7 = 2'bxx;
    do_reset();
    opcode = 7'b0000011;
    for (int c = 1; c <= 8; c++) begin
      imem_ack = (c == 1);
      dmem_ack = (c == 6);
      #1;
      if (dmem_req === 1'b1) req_cnt++;
      if (dmem_we === 1'b1) we_seen = 1'b1;
      if (instr_done === 1'b1 && done_c == 0) begin done_c = c; ws7 = wb_sel; end
      step();
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    checks++;
    if (req_cnt != 3) begin
      failures++;
      $display("FAIL load_dmem_req_cycles: got %0d expected 3", req_cnt);
    end
    checks++;
    if (we_seen !== 1'b0) begin
      failures++;
      $display("FAIL load_dmem_we: got %b expected 0", we_seen);
    end
    checks++;
    if (done_c != 7 || ws7 !== 2'b01) begin
      failures++;
      $display("FAIL load_retire: cycle=%0d wb_sel=%b expected 7/01", done_c, ws7);
    end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      logic rfw_seen = 1'b0;
      logic [2:0] st3 = 3'bxxx;
      logic done3 = 1'bx;
      logic [1:0] ps3 = 2'bxx;
      do_reset();
      opcode = 7'b1100011; branch_taken = (t == 1);
      for (int c = 1; c <= 4; c++) begin
        imem_ack = (c == 1);
        #1;
        if (rf_we === 1'b1) rfw_seen = 1'b1;
        if (c == 3) begin st3 = state; done3 = instr_done; ps3 = pc_src; end
        step();
      end
      imem_ack = 1'b0;
      checks++;
      if (st3 !== 3'd2 || done3 !== 1'b1 || ps3 !== (t == 1 ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL branch_taken%0d: state=%0d done=%b pc_src=%b expected 2/1/%s",
                 t, st3, done3, ps3, (t == 1) ? "01" : "00");
      end
      checks++;
      if (rfw_seen !== 1'b0) begin
        failures++;
        $display("FAIL branch_rf_we%0d: got %b expected 0", t, rfw_seen);
      end
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_illegal();
    int bad = 0;
    do_reset();
    opcode = 7'b1110011; imem_ack = 1'b1;
    step(); imem_ack = 1'b0;
    step(); #1;
    checks++;
    if (state !== 3'd7 || illegal !== 1'b1 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL illegal_trap: state=%0d illegal=%b timeout=%b expected 7/1/0",
               state, illegal, timeout);
    end
    for (int k = 0; k < 20; k++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1; stall = k[0]; branch_taken = 1'b1;
      step();
      if (state !== 3'd7 || illegal !== 1'b1 ||
          {imem_req, ir_we, imm_valid, dmem_req, dmem_we, rf_we, pc_we, instr_done} !== 8'd0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL illegal_absorb: bad_cycles=%0d expected 0", bad);
    end
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    step(); rst = 1'b0; #1;
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL illegal_reset: state=%0d illegal=%b imem_req=%b expected 0/0/1",
               state, illegal, imem_req);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    do_reset();
    opcode = 7'b0010011;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (state !== 3'd0 || imem_req !== 1'b1) bad++;
      step();
    end
    #1;
    checks++;
    if (bad != 0 || state !== 3'd7 || timeout !== 1'b1 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL timeout_trap: state=%0d timeout=%b illegal=%b bad=%0d expected 7/1/0/0",
               state, timeout, illegal, bad);
    end
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      imem_ack = (c == 4);
      #1;
      if (c == 4) begin
        checks++;
        if (ir_we !== 1'b1) begin
          failures++;
          $display("FAIL timeout_ack_ir_we: got %b expected 1", ir_we);
        end
      end
      step();
    end
    imem_ack = 1'b0;
    #1;
    checks++;
    if (state !== 3'd1 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_ack_wins: state=%0d timeout=%b expected 1/0", state, timeout);
    end
    step();
  endtask

  task automatic test_stall_jal();
    int bad = 0;
    do_reset();
    opcode = 7'b1101111; imem_ack = 1'b1; stall = 1'b1;
    #1;
    checks++;
    if (ir_we !== 1'b1) begin
      failures++;
      $display("FAIL stall_fetch_ignored: ir_we=%b expected 1", ir_we);
    end
    step(); imem_ack = 1'b0; stall = 1'b0;
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (state !== 3'd2 || {pc_we, rf_we, instr_done, imm_valid} !== 4'd0) bad++;
      step();
    end
    stall = 1'b0;
    #1;
    checks++;
    if (bad != 0 || state !== 3'd2) begin
      failures++;
      $display("FAIL stall_exec_hold: bad=%0d state=%0d expected 0/2", bad, state);
    end
    step(); #1;
    checks++;
    if ({state, pc_src, wb_sel, instr_done, rf_we} !== {3'd4, 2'b01, 2'b10, 2'b11}) begin
      failures++;
      $display("FAIL stall_jal_wb: state=%0d pc_src=%b wb_sel=%b done=%b expected 4/01/10/1",
               state, pc_src, wb_sel, instr_done);
    end
    step();
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = 7'b0100011; imem_ack = 1'b1;
    step(); imem_ack = 1'b0;
    step();
    step(); #1;
    checks++;
    if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
      failures++;
      $display("FAIL store_mem: state=%0d dmem_req=%b dmem_we=%b expected 3/1/1",
               state, dmem_req, dmem_we);
    end
    step();
    rst = 1'b1; dmem_ack = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || state !== 3'd0 || pc_we !== 1'b0 || instr_done !== 1'b0) begin
      failures++;
      $display("FAIL mem_rst_outputs: dmem_req=%b state=%0d pc_we=%b expected 0/0/0",
               dmem_req, state, pc_we);
    end
    step();
    rst = 1'b0; dmem_ack = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || dmem_req !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL mem_rst_fetch: state=%0d dmem_req=%b imem_req=%b expected 0/0/1",
               state, dmem_req, imem_req);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [1:0] ws, ps;
    logic rfw;
    do_reset();
    imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_zero_wait(tbl_opc[i], lat, ws, ps, rfw);
      checks++;
      if (lat != tbl_lat[i] || ws !== tbl_ws[i] || ps !== tbl_ps[i] || rfw !== tbl_rfw[i]) begin
        failures++;
        $display("FAIL b2b_opc_%b: lat=%0d wb_sel=%b pc_src=%b rf_we=%b expected %0d/%b/%b/%b",
                 tbl_opc[i], lat, ws, ps, rfw, tbl_lat[i], tbl_ws[i], tbl_ps[i], tbl_rfw[i]);
      end
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; branch_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; stall = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_illegal();
    test_timeout();
    test_stall_jal();
    test_reset_mid_mem();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
